// File: rtl/programmable_sequence_detector_pkg.sv
// seqdet_pkg: shared FSM states, length-width helper and masked pattern compare
package seqdet_pkg;
  localparam int CMP_W = 64;
  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_FILL     = 2'd1,
    ST_HUNT     = 2'd2
  } state_t;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
  // Only the low len bits take part; newest history bit lines up with pattern[0].
  function automatic logic masked_eq(input logic [CMP_W-1:0] pat, input logic [CMP_W-1:0] hist,
                                     input int len);
    logic [CMP_W-1:0] mask;
    mask = (len >= CMP_W) ? '1 : (CMP_W'(1) << len) - CMP_W'(1);
    return ((pat ^ hist) & mask) == '0;
  endfunction
endpackage

// File: rtl/programmable_sequence_detector_sat_counter.sv
// sat_counter: counter with sync clear that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
  end
endmodule

// File: rtl/programmable_sequence_detector.sv
// programmable_sequence_detector: runtime-programmable serial pattern detector with match counter
module programmable_sequence_detector
  import seqdet_pkg::*;
#(
  parameter int                 MAX_LEN = 16,
  parameter int                 CNT_W   = 16,
  parameter logic [MAX_LEN-1:0] RST_PAT = 'b1011,
  parameter int                 RST_LEN = 4,
  parameter logic               RST_OVL = 1'b1,
  localparam int                LW      = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_data,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);
  logic [MAX_LEN-1:0] pattern, hist, hist_sh, hist_n;
  logic [LW-1:0]      len, len_c, len_n, fill, fill_inc, fill_n;
  logic               overlap, restart, accept, full, hit, drop;
  state_t             state, state_n;
  always_comb begin
    len_c    = (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
    restart  = clear | cfg_load;
    len_n    = cfg_load ? len_c : len;
    accept   = in_valid && !restart && state != ST_DISABLED;
    hist_sh  = {hist[MAX_LEN-2:0], in_data};
    fill_inc = (fill == len) ? fill : fill + 1'b1;
    full     = fill_inc == len;
    hit      = accept && full && masked_eq(CMP_W'(pattern), CMP_W'(hist_sh), int'(len));
    drop     = hit && !overlap;
    hist_n   = restart ? '0 : accept ? hist_sh : hist;
    fill_n   = (restart || drop) ? '0 : accept ? fill_inc : fill;
    state_n  = restart ? ((len_n != '0) ? ST_FILL : ST_DISABLED) :
               drop ? ST_FILL : (accept && full) ? ST_HUNT : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= RST_PAT;
      len     <= LW'(RST_LEN);
      overlap <= RST_OVL;
      hist    <= '0;
      fill    <= '0;
      state   <= (RST_LEN != 0) ? ST_FILL : ST_DISABLED;
      match   <= 1'b0;
      armed   <= 1'b0;
    end else begin
      pattern <= cfg_load ? cfg_pattern : pattern;
      len     <= len_n;
      overlap <= cfg_load ? cfg_overlap : overlap;
      hist    <= hist_n;
      fill    <= fill_n;
      state   <= state_n;
      match   <= hit;
      armed   <= state_n == ST_HUNT;
    end
  end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .inc  (hit),
    .count(match_count)
  );
endmodule

// File: tb/tb_programmable_sequence_detector.sv
// tb_programmable_sequence_detector: directed + random checks against a queue-based pattern model
module tb_programmable_sequence_detector;
  logic        clk = 1'b0;
  logic        rst_n, clear, cfg_load, cfg_overlap, in_valid, in_data;
  logic [15:0] cfg_pattern;
  logic [4:0]  cfg_len;
  logic        match, armed;
  logic [1:0]  match_count;

  programmable_sequence_detector #(.MAX_LEN(16), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .in_valid(in_valid), .in_data(in_data),
    .match(match), .match_count(match_count), .armed(armed)
  );

  always #5 clk = ~clk;

  bit          q[$];
  logic [15:0] mpat;
  int          mlen, mcnt, total, bad, npulse;
  bit          movl, em;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mpat = 16'b1011; mlen = 4; movl = 1'b1; mcnt = 0; em = 1'b0;
    q.delete();
  endtask

  task automatic step(input logic v, input logic d, input logic clr, input logic ld);
    in_valid = v; in_data = d; clear = clr; cfg_load = ld;
    @(posedge clk);
    em = 1'b0;
    if (clr || ld) begin
      if (ld) begin
        mpat = cfg_pattern;
        mlen = (cfg_len > 16) ? 16 : int'(cfg_len);
        movl = cfg_overlap;
      end
      q.delete();
      if (clr) mcnt = 0;
    end else if (v && mlen != 0) begin
      q.push_back(d);
      if (q.size() >= mlen) begin
        em = 1'b1;
        for (int i = 0; i < mlen; i++)
          if (q[q.size() - mlen + i] != mpat[mlen - 1 - i]) em = 1'b0;
      end
      if (em) begin
        mcnt = (mcnt == 3) ? 3 : mcnt + 1;
        if (!movl) q.delete();
      end
      if (q.size() > 32) void'(q.pop_front());
    end
    #1;
    chk("match", 32'(match), 32'(em));
    chk("count", 32'(match_count), 32'(mcnt));
    chk("armed", 32'(armed), 32'(mlen != 0 && q.size() >= mlen));
    if (match === 1'b1) npulse++;
    in_valid = 1'b0; clear = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 1'b0);
  endtask

  task automatic cfg(input logic [15:0] p, input logic [4:0] l, input logic o, input logic clr);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    step(1'b0, 1'b0, clr, 1'b1);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_match", 32'(match), 0);
    chk("rst_count", 32'(match_count), 0);
    chk("rst_armed", 32'(armed), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0; npulse = 0;
    rst_n = 1'b0; clear = 1'b0; cfg_load = 1'b0; in_valid = 1'b0; in_data = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    model_reset();
    #12;
    chk("reset_match", 32'(match), 0);
    chk("reset_count", 32'(match_count), 0);
    chk("reset_armed", 32'(armed), 0);
    rst_n = 1'b1;
    // default 1011, overlapping
    npulse = 0;
    send(32'b1011011, 7);
    chk("t1_pulses", 32'(npulse), 2);
    chk("t1_count", 32'(match_count), 2);
    // non-overlapping, clear and load together
    cfg(16'b1011, 5'd4, 1'b0, 1'b1);
    npulse = 0;
    send(32'b1011011, 7);
    chk("t2_pulses", 32'(npulse), 1);
    chk("t2_count", 32'(match_count), 1);
    // gaps in in_valid
    cfg(16'b1011, 5'd4, 1'b1, 1'b0);
    npulse = 0;
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, 1'((7'b1011011 >> i) & 1), 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("t3_pulses", 32'(npulse), 2);
    chk("t3_count", 32'(match_count), 3);
    // reprogram mid-stream to 0x7E, len 8
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    cfg(16'h007E, 5'd8, 1'b1, 1'b0);
    npulse = 0;
    send(32'b0111111, 7);
    chk("t4_early", 32'(npulse), 0);
    send(32'b0, 1);
    chk("t4_pulses", 32'(npulse), 1);
    // len 1, saturation at 3
    cfg(16'h0001, 5'd1, 1'b0, 1'b1);
    npulse = 0;
    send(32'b11111, 5);
    chk("t5_pulses", 32'(npulse), 5);
    chk("t5_count", 32'(match_count), 3);
    send(32'b0, 1);
    // random traffic with short patterns, occasional clear/load collisions
    for (int n = 0; n < 2000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      cfg_pattern = 16'($urandom);
      cfg_len = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 4));
      cfg_overlap = 1'($urandom_range(0, 1));
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), r < 3, r >= 2 && r < 6);
    end
    // async reset with a match pulse on the output, then mid-pattern
    cfg(16'b1011, 5'd4, 1'b1, 1'b1);
    send(32'b1011, 4);
    chk("t6_pre_match", 32'(match), 1);
    async_reset();
    send(32'b101, 3);
    async_reset();
    npulse = 0;
    send(32'b1, 1);
    chk("t6_pulses", 32'(npulse), 0);
    chk("t6_count", 32'(match_count), 0);
    // len 0 disables
    cfg(16'h0000, 5'd0, 1'b1, 1'b0);
    npulse = 0;
    for (int i = 0; i < 40; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    chk("t6_dis_pulses", 32'(npulse), 0);
    chk("t6_dis_armed", 32'(armed), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
